iter_divider: RTL and testbench

Sequential radix-2 restoring divider for the EX stage of the 5-stage MIPS pipeline; it services DIV and DIVU and writes HI (remainder) and LO (quotient). It is the division counterpart of the Booth/partial-sum multiplier path. It accepts one 32-bit operation at a time, iterates one quotient bit per cycle, and reports completion with a one-cycle pulse. The pipeline stalls EX while the divider is busy. A flush cancels the operation in flight.

---
 rtl/iter_divider.sv | 159 +++++++++++++++
 tb/tb_iter_divider.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/iter_divider.sv
// iter_divider: sequential radix-2 restoring divider for DIV/DIVU.
// Produces one quotient bit per cycle over unsigned magnitudes, then fixes up
// the signs. Divide by zero returns all-ones quotient and the dividend as remainder.
//
// Handshake: a request is accepted on a rising edge where div_valid && div_ready.
// div_ready is high only when idle. div_complete pulses for exactly one cycle,
// and s/r are valid in that cycle. s/r then hold until the next result.
// div_cancel abandons an operation in flight but is ignored while idle.
module iter_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             div_valid,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] div_x,
  input  logic [WIDTH-1:0] div_y,
  input  logic             div_cancel,
  output logic             div_ready,
  output logic             div_busy,
  output logic             div_complete,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] r,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [5:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] ay_q, ay_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic             sign_q_q, sign_q_d;
  logic             sign_r_q, sign_r_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [WIDTH-1:0] r_q, r_d;

  // The bit shifted out of rem[31] is kept as the top of the trial operand,
  // so divisors of 2^31 and above still divide correctly.
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] trial;

  assign rem_sh = {rem_q, quo_q[WIDTH-1]};
  assign trial  = {1'b0, rem_sh} - {2'b00, ay_q};

  // Outputs decode directly from registered state, so they carry no input paths.
  assign div_ready    = (state_q == IDLE);
  assign div_busy     = (state_q != IDLE);
  assign div_complete = (state_q == DONE);
  assign s            = s_q;
  assign r            = r_q;
  assign dbg_state    = state_q;

  // Next-state logic: accept, iterate, sign fix-up, completion, and cancel.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    ay_d     = ay_q;
    x_d      = x_q;
    sign_q_d = sign_q_q;
    sign_r_d = sign_r_q;
    dz_d     = dz_q;
    s_d      = s_q;
    r_d      = r_q;

    case (state_q)
      IDLE: begin
        if (div_valid) begin
          state_d  = CALC;
          cnt_d    = 6'd0;
          rem_d    = '0;
          quo_d    = (div_signed && div_x[WIDTH-1]) ? (~div_x + 1'b1) : div_x;
          ay_d     = (div_signed && div_y[WIDTH-1]) ? (~div_y + 1'b1) : div_y;
          x_d      = div_x;
          sign_q_d = div_signed & (div_x[WIDTH-1] ^ div_y[WIDTH-1]);
          sign_r_d = div_signed & div_x[WIDTH-1];
          dz_d     = (div_y == '0);
        end
      end
      CALC: begin
        if (cnt_q == 6'd32) begin
          state_d = FIX;
        end else begin
          cnt_d = cnt_q + 6'd1;
          if (!trial[WIDTH+1]) begin
            rem_d = trial[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d = rem_sh[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
          end
        end
      end
      FIX: begin
        state_d = DONE;
        if (dz_q) begin
          s_d = '1;
          r_d = x_q;
        end else begin
          s_d = sign_q_q ? (~quo_q + 1'b1) : quo_q;
          r_d = sign_r_q ? (~rem_q + 1'b1) : rem_q;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A flush drops the operation in flight without touching the result regs.
    if (div_cancel && (state_q != IDLE)) begin
      state_d = IDLE;
      s_d     = s_q;
      r_d     = r_q;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= IDLE;
      cnt_q    <= 6'd0;
      rem_q    <= '0;
      quo_q    <= '0;
      ay_q     <= '0;
      x_q      <= '0;
      sign_q_q <= 1'b0;
      sign_r_q <= 1'b0;
      dz_q     <= 1'b0;
      s_q      <= '0;
      r_q      <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      ay_q     <= ay_d;
      x_q      <= x_d;
      sign_q_q <= sign_q_d;
      sign_r_q <= sign_r_d;
      dz_q     <= dz_d;
      s_q      <= s_d;
      r_q      <= r_d;
    end
  end

endmodule

// File: tb/tb_iter_divider.sv
// tb_iter_divider: directed and randomized checks of iter_divider against a
// plain-arithmetic reference (truncating division, remainder takes dividend sign).
module tb_iter_divider;

  logic        clk = 1'b0;
  logic        resetn;
  logic        div_valid;
  logic        div_signed;
  logic [31:0] div_x;
  logic [31:0] div_y;
  logic        div_cancel;
  logic        div_ready;
  logic        div_busy;
  logic        div_complete;
  logic [31:0] s;
  logic [31:0] r;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;

  iter_divider #(.WIDTH(32)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .div_valid    (div_valid),
    .div_signed   (div_signed),
    .div_x        (div_x),
    .div_y        (div_y),
    .div_cancel   (div_cancel),
    .div_ready    (div_ready),
    .div_busy     (div_busy),
    .div_complete (div_complete),
    .s            (s),
    .r            (r),
    .dbg_state    (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: MIPS DIV/DIVU semantics in plain arithmetic.
  task automatic ref_div(input logic sgn, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] qs, output logic [31:0] rs);
    longint sx, sy, lq, lr;
    if (y == 32'd0) begin
      qs = 32'hFFFF_FFFF;
      rs = x;
    end else if (sgn) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      lq = sx / sy;
      lr = sx % sy;
      qs = lq[31:0];
      rs = lr[31:0];
    end else begin
      qs = x / y;
      rs = x % y;
    end
  endtask

  // Issue one op, scramble operands after acceptance, wait for completion, check.
  task automatic run_op(input string tag, input logic sgn, input logic [31:0] x,
                        input logic [31:0] y, input logic with_cancel);
    logic [31:0] es, er;
    int n;
    bit seen_ready;
    ref_div(sgn, x, y, es, er);
    n = 0;
    while (!div_ready && n < 100) begin
      tick();
      n++;
    end
    check({tag, "_ready_before"}, 32'(div_ready), 32'd1);
    div_valid  = 1'b1;
    div_signed = sgn;
    div_x      = x;
    div_y      = y;
    div_cancel = with_cancel;
    tick();
    div_valid  = 1'b0;
    div_cancel = 1'b0;
    check({tag, "_busy_after_accept"}, 32'(div_busy), 32'd1);
    div_x      = $urandom;
    div_y      = $urandom;
    div_signed = 1'($urandom_range(0, 1));
    n = 0;
    seen_ready = 1'b0;
    while (!div_complete && n < 100) begin
      tick();
      n++;
      if (div_ready) seen_ready = 1'b1;
    end
    check({tag, "_complete"}, 32'(div_complete), 32'd1);
    check({tag, "_latency"}, 32'(n), 32'd34);
    check({tag, "_ready_low"}, 32'(seen_ready), 32'd0);
    check({tag, "_s"}, s, es);
    check({tag, "_r"}, r, er);
    tick();
    check({tag, "_complete_single"}, 32'(div_complete), 32'd0);
    check({tag, "_ready_after"}, 32'(div_ready), 32'd1);
  endtask

  initial begin
    logic        sgn;
    logic [31:0] x, y;

    // Reset
    resetn     = 1'b0;
    div_valid  = 1'b0;
    div_signed = 1'b0;
    div_x      = '0;
    div_y      = '0;
    div_cancel = 1'b0;
    tick();
    tick();
    check("rst_ready", 32'(div_ready), 32'd1);
    check("rst_busy", 32'(div_busy), 32'd0);
    check("rst_complete", 32'(div_complete), 32'd0);
    check("rst_s", s, 32'd0);
    check("rst_r", r, 32'd0);
    resetn = 1'b1;
    tick();

    // Directed values
    run_op("divu_100_7", 1'b0, 32'd100, 32'd7, 1'b0);
    run_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 1'b0);
    run_op("div_m7_m2", 1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b0);
    run_op("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0);
    run_op("divu_big_div", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
    run_op("div_dz", 1'b1, 32'h1234_5678, 32'd0, 1'b0);
    run_op("divu_dz", 1'b0, 32'h1234_5678, 32'd0, 1'b0);
    run_op("div_valid_cancel", 1'b1, 32'd1000, 32'd3, 1'b1);
    run_op("divu_5_9", 1'b0, 32'd5, 32'd9, 1'b0);

    // Cancel at cycle 10: no completion, results held from 5/9
    div_valid  = 1'b1;
    div_signed = 1'b0;
    div_x      = 32'd100;
    div_y      = 32'd7;
    tick();
    div_valid = 1'b0;
    repeat (9) tick();
    check("cancel_pre_busy", 32'(div_busy), 32'd1);
    div_cancel = 1'b1;
    tick();
    div_cancel = 1'b0;
    check("cancel_ready", 32'(div_ready), 32'd1);
    check("cancel_complete", 32'(div_complete), 32'd0);
    check("cancel_s_hold", s, 32'd0);
    check("cancel_r_hold", r, 32'd5);
    run_op("after_cancel_50_5", 1'b0, 32'd50, 32'd5, 1'b0);

    // Reset at cycle 20 mid-operation
    div_valid  = 1'b1;
    div_signed = 1'b0;
    div_x      = 32'd100;
    div_y      = 32'd7;
    tick();
    div_valid = 1'b0;
    repeat (19) tick();
    resetn = 1'b0;
    tick();
    check("midrst_ready", 32'(div_ready), 32'd1);
    check("midrst_busy", 32'(div_busy), 32'd0);
    check("midrst_complete", 32'(div_complete), 32'd0);
    check("midrst_s", s, 32'd0);
    check("midrst_r", r, 32'd0);
    resetn = 1'b1;
    tick();

    // Randomized operands, back-to-back issue
    for (int i = 0; i < 1500; i++) begin
      sgn = 1'($urandom_range(0, 1));
      x   = $urandom;
      case ($urandom_range(0, 7))
        0:       y = 32'd0;
        1:       y = 32'($urandom_range(1, 15));
        2:       y = 32'hFFFF_FFFF;
        3:       y = 32'h8000_0000 | $urandom;
        default: y = $urandom;
      endcase
      if ($urandom_range(0, 15) == 0) x = 32'h8000_0000;
      run_op("rnd", sgn, x, y, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
